// File: rtl/operand_select_pipe_pkg.sv
// Shared definitions for the ECC operand selector: default field width,
// default source count and the skid-buffer occupancy encoding.
package operand_select_pipe_pkg;

  localparam int FIELD_W     = 233;
  localparam int DEF_NUM_SRC = 8;
  localparam int DEF_SEL_W   = 3;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/operand_select_pipe_skid_buf2.sv
// Two-entry valid/ready skid buffer. The head register drives the outputs
// directly; the skid register absorbs the one entry that arrives after the
// consumer stalls, because in_ready is registered and lags by a cycle.
module operand_select_pipe_skid_buf2
  import operand_select_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state;
  logic [W-1:0] skid_p1;
  logic         acc;
  logic         pop;

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  // Occupancy FSM with registered handshake flags and the head data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
    end else if (clear) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            out_data <= in_data;
          end else if (acc) begin
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            out_data <= skid_p1;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Skid data register: loaded only when the head is busy and not draining.
  always_ff @(posedge clk) begin
    if (!clear && state == ST_ONE && acc && !pop) begin
      skid_p1 <= in_data;
    end
  end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered dual-operand selector for the GF(2^m) ECC datapath. Two
// independent NUM_SRC-way decoders pick X and Y from the flattened source
// bank; out-of-range indices give a zero operand and flag an error. The
// selection is registered through a 2-entry skid buffer so every output
// comes straight from a flop. NUM_SRC must not exceed 2**SEL_W.
module operand_select_pipe
  import operand_select_pipe_pkg::*;
#(
  parameter int N       = FIELD_W,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = DEF_SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [NUM_SRC*N-1:0] src,
  input  logic [SEL_W-1:0]   sel_x,
  input  logic [SEL_W-1:0]   sel_y,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       out_x,
  output logic [N-1:0]       out_y,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int BUF_W = 2 * N + 1;

  logic [N-1:0]     x_p0;
  logic [N-1:0]     y_p0;
  logic             hit_x_p0;
  logic             hit_y_p0;
  logic             err_p0;
  logic [BUF_W-1:0] buf_p1;

  // Index decoders: an index that matches no source leaves the operand zero.
  always_comb begin
    x_p0     = '0;
    y_p0     = '0;
    hit_x_p0 = 1'b0;
    hit_y_p0 = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_x == SEL_W'(k)) begin
        x_p0     = src[k*N +: N];
        hit_x_p0 = 1'b1;
      end
      if (sel_y == SEL_W'(k)) begin
        y_p0     = src[k*N +: N];
        hit_y_p0 = 1'b1;
      end
    end
  end

  assign err_p0 = !hit_x_p0 || !hit_y_p0;

  // Stage p0 -> p1: selection captured into the skid buffer.
  operand_select_pipe_skid_buf2 #(
    .W (BUF_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   ({err_p0, y_p0, x_p0}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (buf_p1),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_x   = buf_p1[N-1:0];
  assign out_y   = buf_p1[2*N-1:N];
  assign out_err = buf_p1[2*N];

endmodule

// File: tb/tb_operand_select_pipe.sv
// Bench for operand_select_pipe: an 8-source and a 7-source build share the
// same stimulus; a queue-based FIFO model predicts both.
module tb_operand_select_pipe;

  localparam int N = 233;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic [N-1:0]   srcv [8];
  logic [8*N-1:0] src;
  logic [2:0]     sel_x;
  logic [2:0]     sel_y;
  logic           in_valid;
  logic           out_ready;

  logic [N-1:0] x8, y8, x7, y7;
  logic         e8, v8, r8, e7, v7, r7;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] x8;
    logic [N-1:0] y8;
    logic         e8;
    logic [N-1:0] x7;
    logic [N-1:0] y7;
    logic         e7;
  } ent_t;

  ent_t q[$];
  bit   last_acc;

  always_comb begin
    for (int k = 0; k < 8; k++) src[k*N +: N] = srcv[k];
  end

  operand_select_pipe #(.N(N), .NUM_SRC(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .src(src),
    .sel_x(sel_x), .sel_y(sel_y), .in_valid(in_valid), .in_ready(r8),
    .out_x(x8), .out_y(y8), .out_err(e8), .out_valid(v8), .out_ready(out_ready)
  );

  operand_select_pipe #(.N(N), .NUM_SRC(7), .SEL_W(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .src(src[7*N-1:0]),
    .sel_x(sel_x), .sel_y(sel_y), .in_valid(in_valid), .in_ready(r7),
    .out_x(x7), .out_y(y7), .out_err(e7), .out_valid(v7), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] pick(int sel, int nsrc);
    return (sel < nsrc) ? srcv[sel] : '0;
  endfunction

  function automatic ent_t mk(int sx, int sy);
    ent_t e;
    e.x8 = pick(sx, 8);
    e.y8 = pick(sy, 8);
    e.e8 = (sx >= 8) || (sy >= 8);
    e.x7 = pick(sx, 7);
    e.y7 = pick(sy, 7);
    e.e7 = (sx >= 7) || (sy >= 7);
    return e;
  endfunction

  task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid8", N'(v8), N'(q.size() > 0));
    chk("ready8", N'(r8), N'(q.size() < 2));
    chk("valid7", N'(v7), N'(q.size() > 0));
    chk("ready7", N'(r7), N'(q.size() < 2));
    if (q.size() > 0) begin
      chk("x8", x8, q[0].x8);
      chk("y8", y8, q[0].y8);
      chk("err8", N'(e8), N'(q[0].e8));
      chk("x7", x7, q[0].x7);
      chk("y7", y7, q[0].y7);
      chk("err7", N'(e7), N'(q[0].e7));
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_valid"}, N'(v8 | v7), '0);
    chk({tag, "_ready"}, N'(r8 & r7), N'(1));
    chk({tag, "_x"}, x8 | x7, '0);
    chk({tag, "_y"}, y8 | y7, '0);
    chk({tag, "_err"}, N'(e8 | e7), '0);
  endtask

  // One clock: predict from pre-edge inputs, advance model, check at negedge.
  task automatic cycle();
    bit   acc;
    bit   pop;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    pop = out_ready && (q.size() > 0);
    e   = mk(int'(sel_x), int'(sel_y));
    @(posedge clk);
    if (clear) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    last_acc = acc && !clear;
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_src();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
      srcv[k] = w[N-1:0];
    end
  endtask

  initial begin
    int r;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel_x = '0; sel_y = '0;
    for (int k = 0; k < 8; k++) srcv[k] = N'(k + 1);
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Single request
    sel_x = 3'd3; sel_y = 3'd5; in_valid = 1'b1;
    cycle();
    chk("s1_x", x8, N'(4));
    chk("s1_y", y8, N'(6));
    chk("s1_err", N'(e8), '0);
    chk("s1_valid", N'(v8), N'(1));
    in_valid = 1'b0;
    cycle();
    chk("s1_once", N'(v8), '0);

    // Full-rate stream
    for (int i = 0; i < 16; i++) begin
      sel_x = 3'(i % 8); sel_y = 3'(7 - (i % 8)); in_valid = 1'b1;
      cycle();
      chk("s2_ready", N'(r8), N'(1));
    end
    in_valid = 1'b0;
    cycle();

    // Back-pressure: two absorbed, third held off until drain
    out_ready = 1'b0; r = 0;
    for (int c = 0; c < 4; c++) begin
      sel_x = 3'(r); sel_y = 3'(r + 4); in_valid = (r < 3);
      cycle();
      if (last_acc) r++;
    end
    chk("s3_held", N'(r), N'(2));
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sel_x = 3'(r); sel_y = 3'(r + 4); in_valid = (r < 3);
      cycle();
      if (last_acc) r++;
    end
    chk("s3_third", N'(r), N'(3));
    in_valid = 1'b0;
    cycle();

    // Out-of-range on the 7-source build, and equal selects
    sel_x = 3'd2; sel_y = 3'd7; in_valid = 1'b1;
    cycle();
    chk("s4_x7", x7, N'(3));
    chk("s4_y7", y7, '0);
    chk("s4_err7", N'(e7), N'(1));
    sel_x = 3'd6; sel_y = 3'd6;
    cycle();
    chk("s4_same_x", x7, N'(7));
    chk("s4_same_y", y7, N'(7));
    in_valid = 1'b0;
    cycle();

    // Flush with a simultaneous request
    out_ready = 1'b0; in_valid = 1'b1; sel_x = 3'd1; sel_y = 3'd2;
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    chk("s5_valid", N'(v8), '0);
    chk("s5_ready", N'(r8), N'(1));
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      sel_x = 3'(i + 1); sel_y = 3'(i + 2); in_valid = 1'b1; out_ready = (i != 1);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1 check_reset("s6_async");
    q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    sel_x = 3'd3; sel_y = 3'd5; in_valid = 1'b1;
    cycle();
    chk("s6_x", x8, N'(4));
    chk("s6_y", y8, N'(6));
    in_valid = 1'b0;
    cycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) rand_src();
      sel_x     = 3'($urandom_range(0, 7));
      sel_y     = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
